core_bypass_ctrl: RTL and testbench

CORE_BYPASS_CTRL -- requirements
Module: core_bypass_ctrl

---
 rtl/core_bypass_ctrl_pkg.sv | 41 ++++
 rtl/core_bypass_ctrl_sel.sv | 25 ++
 rtl/core_bypass_ctrl.sv | 121 ++++++++++++
 tb/tb_core_bypass_ctrl.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/core_bypass_ctrl_pkg.sv
// Shared definitions for the core bypass/hazard tracker: bypass select
// encodings, the per-stage slot record, the load-use FSM states and the
// debug view of the tracker state.
package core_bypass_ctrl_pkg;

    localparam logic [1:0] STAGED_BP_NONE     = 2'd0;
    localparam logic [1:0] STAGED_BP_MEMORY   = 2'd1;
    localparam logic [1:0] STAGED_BP_WRITE    = 2'd2;
    localparam logic [1:0] STAGED_BP_WRITE_BK = 2'd3;

    // One in-flight instruction as seen by the bypass network.
    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       rd_we;
        logic       is_load;
    } stage_slot_t;

    localparam stage_slot_t SLOT_BUBBLE = '0;

    typedef enum logic {
        RUN     = 1'b0,
        LU_WAIT = 1'b1
    } lu_state_t;

    // Full tracker state, exported so checkers can bind to it directly.
    typedef struct packed {
        lu_state_t   state;
        stage_slot_t exec_slot;
        stage_slot_t mem_slot;
        stage_slot_t write_slot;
        stage_slot_t wb_slot;
    } dbg_t;

    // A slot produces a source when it will really write that register;
    // x0 is never a producer because writes to it are discarded.
    function automatic logic slot_match(input stage_slot_t s, input logic [4:0] idx);
        return s.valid && s.rd_we && (s.rd != 5'd0) && (s.rd == idx);
    endfunction

endpackage

// File: rtl/core_bypass_ctrl_sel.sv
// Bypass source select for one source operand: the nearest in-flight
// producer wins (exec, then memory, then write).
module core_bypass_sel
    import core_bypass_ctrl_pkg::*;
(
    input  stage_slot_t exec_slot,
    input  stage_slot_t mem_slot,
    input  stage_slot_t write_slot,
    input  logic [4:0]  src,
    output logic [1:0]  sel
);

    // Priority pick of the youngest matching producer.
    always_comb begin
        sel = STAGED_BP_NONE;
        if (slot_match(exec_slot, src)) begin
            sel = STAGED_BP_MEMORY;
        end else if (slot_match(mem_slot, src)) begin
            sel = STAGED_BP_WRITE;
        end else if (slot_match(write_slot, src)) begin
            sel = STAGED_BP_WRITE_BK;
        end
    end

endmodule

// File: rtl/core_bypass_ctrl.sv
// Bypass and load-use hazard controller. Tracks the four stages behind
// decode, registers the operand bypass selects for the instruction entering
// exec, and inserts one bubble when a load's result is consumed immediately.
module core_bypass_ctrl
    import core_bypass_ctrl_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_dec_valid,
    input  logic [4:0] i_dec_rs1,
    input  logic [4:0] i_dec_rs2,
    input  logic [4:0] i_dec_rd,
    input  logic       i_dec_rd_we,
    input  logic       i_dec_is_load,
    input  logic       i_hold,
    input  logic       i_flush,
    output logic [1:0] o_bp_rs1,
    output logic [1:0] o_bp_rs2,
    output logic       o_stall_dec,
    output logic       o_bubble_exec,
    output dbg_t       o_dbg
);

    stage_slot_t exec_q, mem_q, write_q, wb_q;
    stage_slot_t dec_slot;
    lu_state_t   state_q, state_d;
    logic [1:0]  sel_rs1, sel_rs2;
    logic        load_use;
    logic        exec_gets_bubble;

    core_bypass_sel u_sel_rs1 (
        .exec_slot  (exec_q),
        .mem_slot   (mem_q),
        .write_slot (write_q),
        .src        (i_dec_rs1),
        .sel        (sel_rs1)
    );

    core_bypass_sel u_sel_rs2 (
        .exec_slot  (exec_q),
        .mem_slot   (mem_q),
        .write_slot (write_q),
        .src        (i_dec_rs2),
        .sel        (sel_rs2)
    );

    // Hazard detection and the slot the decode instruction would occupy.
    // In LU_WAIT the load has already moved to memory, so no second stall.
    always_comb begin
        load_use = 1'b0;
        if ((state_q == RUN) && i_dec_valid && exec_q.is_load) begin
            load_use = slot_match(exec_q, i_dec_rs1) || slot_match(exec_q, i_dec_rs2);
        end
        o_stall_dec = 1'b0;
        if (!i_reset) begin
            o_stall_dec = i_hold || (load_use && !i_flush);
        end
        // Flush kills decode; a load-use stall holds it back one cycle.
        exec_gets_bubble = load_use || i_flush || !i_dec_valid;
        dec_slot         = '{valid: 1'b1, rd: i_dec_rd, rd_we: i_dec_rd_we,
                             is_load: i_dec_is_load};
        o_bubble_exec    = !exec_q.valid;
    end

    // Load-use FSM next state; a flush always returns to RUN.
    always_comb begin
        state_d = state_q;
        if (!i_hold) begin
            if (i_flush) begin
                state_d = RUN;
            end else begin
                case (state_q)
                    RUN:     if (load_use) state_d = LU_WAIT;
                    LU_WAIT: state_d = RUN;
                    default: state_d = RUN;
                endcase
            end
        end
    end

    // FSM state register.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Stage slot shift and registered bypass selects; frozen while held.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            exec_q   <= SLOT_BUBBLE;
            mem_q    <= SLOT_BUBBLE;
            write_q  <= SLOT_BUBBLE;
            wb_q     <= SLOT_BUBBLE;
            o_bp_rs1 <= STAGED_BP_NONE;
            o_bp_rs2 <= STAGED_BP_NONE;
        end else if (!i_hold) begin
            wb_q    <= write_q;
            write_q <= mem_q;
            mem_q   <= i_flush ? SLOT_BUBBLE : exec_q;
            if (exec_gets_bubble) begin
                exec_q   <= SLOT_BUBBLE;
                o_bp_rs1 <= STAGED_BP_NONE;
                o_bp_rs2 <= STAGED_BP_NONE;
            end else begin
                exec_q   <= dec_slot;
                o_bp_rs1 <= sel_rs1;
                o_bp_rs2 <= sel_rs2;
            end
        end
    end

    // Debug view of the whole tracker.
    always_comb begin
        o_dbg = '{state: state_q, exec_slot: exec_q, mem_slot: mem_q,
                  write_slot: write_q, wb_slot: wb_q};
    end

endmodule

// File: tb/tb_core_bypass_ctrl.sv
// Directed bench for core_bypass_ctrl: back-to-back bypass, load-use,
// x0 handling, producer distance priority, flush, hold and reset cases.
module tb_core_bypass_ctrl;
    import core_bypass_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       dec_valid;
    logic [4:0] dec_rs1, dec_rs2, dec_rd;
    logic       dec_rd_we, dec_is_load;
    logic       hold, flush;
    logic [1:0] bp_rs1, bp_rs2;
    logic       stall_dec, bubble_exec;
    dbg_t       dbg;

    int total = 0;
    int bad   = 0;

    // Clock.
    always #5 clk = ~clk;

    core_bypass_ctrl dut (
        .i_clk         (clk),
        .i_reset       (rst),
        .i_dec_valid   (dec_valid),
        .i_dec_rs1     (dec_rs1),
        .i_dec_rs2     (dec_rs2),
        .i_dec_rd      (dec_rd),
        .i_dec_rd_we   (dec_rd_we),
        .i_dec_is_load (dec_is_load),
        .i_hold        (hold),
        .i_flush       (flush),
        .o_bp_rs1      (bp_rs1),
        .o_bp_rs2      (bp_rs2),
        .o_stall_dec   (stall_dec),
        .o_bubble_exec (bubble_exec),
        .o_dbg         (dbg)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_dec(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                           input logic [4:0] rd, input logic we, input logic ld);
        dec_valid   = v;
        dec_rs1     = rs1;
        dec_rs2     = rs2;
        dec_rd      = rd;
        dec_rd_we   = we;
        dec_is_load = ld;
        #1;
    endtask

    task automatic idle();
        set_dec(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    endtask

    task automatic check_reset_outs(input string tag);
        check({tag, ".bp1"},    32'(bp_rs1),      32'd0);
        check({tag, ".bp2"},    32'(bp_rs2),      32'd0);
        check({tag, ".stall"},  32'(stall_dec),   32'd0);
        check({tag, ".bubble"}, 32'(bubble_exec), 32'd1);
        check({tag, ".state"},  32'(dbg.state),   32'(RUN));
    endtask

    task automatic do_reset(input string tag);
        rst   = 1'b1;
        hold  = 1'b0;
        flush = 1'b0;
        idle();
        step();
        check_reset_outs(tag);
        rst = 1'b0;
        #1;
    endtask

    initial begin
        rst = 1'b1;
        hold = 1'b0;
        flush = 1'b0;
        idle();

        // Back-to-back ALU dependency on rs1.
        do_reset("rst0");
        set_dec(1'b1, 5'd1, 5'd2, 5'd5, 1'b1, 1'b0);
        step();
        check("alu.bubble_prod", 32'(bubble_exec), 32'd0);
        set_dec(1'b1, 5'd5, 5'd1, 5'd6, 1'b1, 1'b0);
        check("alu.no_stall", 32'(stall_dec), 32'd0);
        step();
        check("alu.bp1", 32'(bp_rs1), 32'(STAGED_BP_MEMORY));
        check("alu.bp2", 32'(bp_rs2), 32'(STAGED_BP_NONE));

        // Load-use on rs2: one stall, one bubble, then WRITE bypass.
        do_reset("rst1");
        set_dec(1'b1, 5'd1, 5'd0, 5'd7, 1'b1, 1'b1);
        step();
        set_dec(1'b1, 5'd1, 5'd7, 5'd8, 1'b1, 1'b0);
        check("lu.stall", 32'(stall_dec), 32'd1);
        step();
        check("lu.bubble",     32'(bubble_exec), 32'd1);
        check("lu.state_wait", 32'(dbg.state),   32'(LU_WAIT));
        check("lu.no_2nd",     32'(stall_dec),   32'd0);
        check("lu.bub_bp2",    32'(bp_rs2),      32'(STAGED_BP_NONE));
        step();
        check("lu.bp2",       32'(bp_rs2),      32'(STAGED_BP_WRITE));
        check("lu.bp1",       32'(bp_rs1),      32'(STAGED_BP_NONE));
        check("lu.exec_v",    32'(bubble_exec), 32'd0);
        check("lu.state_run", 32'(dbg.state),   32'(RUN));

        // x0 is never bypassed, at any distance.
        do_reset("rst2");
        set_dec(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0);
        step();
        set_dec(1'b1, 5'd0, 5'd0, 5'd9, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("x0.bp1_d%0d", i + 1), 32'(bp_rs1), 32'd0);
            check($sformatf("x0.bp2_d%0d", i + 1), 32'(bp_rs2), 32'd0);
        end

        // x3 producers at distance 1 and 3: nearest wins.
        do_reset("rst3");
        set_dec(1'b1, 5'd0, 5'd0, 5'd3, 1'b1, 1'b0);
        step();
        set_dec(1'b1, 5'd0, 5'd0, 5'd10, 1'b1, 1'b0);
        step();
        set_dec(1'b1, 5'd0, 5'd0, 5'd3, 1'b1, 1'b0);
        step();
        set_dec(1'b1, 5'd3, 5'd0, 5'd11, 1'b1, 1'b0);
        step();
        check("dist.near_bp1", 32'(bp_rs1), 32'(STAGED_BP_MEMORY));

        // Only the distance-3 producer.
        do_reset("rst4");
        set_dec(1'b1, 5'd0, 5'd0, 5'd3, 1'b1, 1'b0);
        step();
        set_dec(1'b1, 5'd0, 5'd0, 5'd10, 1'b1, 1'b0);
        step();
        step();
        set_dec(1'b1, 5'd3, 5'd0, 5'd11, 1'b1, 1'b0);
        step();
        check("dist.far_bp1", 32'(bp_rs1), 32'(STAGED_BP_WRITE_BK));
        check("dist.far_bp2", 32'(bp_rs2), 32'(STAGED_BP_NONE));

        // Load-use coincident with flush: flush wins.
        do_reset("rst5");
        set_dec(1'b1, 5'd1, 5'd0, 5'd7, 1'b1, 1'b1);
        step();
        set_dec(1'b1, 5'd1, 5'd7, 5'd8, 1'b1, 1'b0);
        flush = 1'b1;
        #1;
        check("fl.stall", 32'(stall_dec), 32'd0);
        step();
        flush = 1'b0;
        #1;
        check("fl.exec_bub", 32'(bubble_exec),        32'd1);
        check("fl.mem_bub",  32'(dbg.mem_slot.valid), 32'd0);
        check("fl.state",    32'(dbg.state),          32'(RUN));
        step();
        check("fl.bp2_after", 32'(bp_rs2), 32'(STAGED_BP_NONE));

        // Hold and flush together: hold first, flush applied on release.
        do_reset("rst6");
        set_dec(1'b1, 5'd1, 5'd2, 5'd5, 1'b1, 1'b0);
        step();
        set_dec(1'b1, 5'd5, 5'd0, 5'd6, 1'b1, 1'b0);
        hold  = 1'b1;
        flush = 1'b1;
        step();
        check("hf.exec_kept", 32'(bubble_exec), 32'd0);
        check("hf.stall",     32'(stall_dec),   32'd1);
        hold = 1'b0;
        step();
        flush = 1'b0;
        #1;
        check("hf.exec_bub", 32'(bubble_exec),        32'd1);
        check("hf.mem_bub",  32'(dbg.mem_slot.valid), 32'd0);

        // Hold mid-sequence, then reset during LU_WAIT under hold.
        do_reset("rst7");
        set_dec(1'b1, 5'd1, 5'd2, 5'd5, 1'b1, 1'b0);
        step();
        set_dec(1'b1, 5'd5, 5'd0, 5'd6, 1'b1, 1'b0);
        step();
        set_dec(1'b1, 5'd0, 5'd6, 5'd12, 1'b1, 1'b0);
        hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("hold.bp1_c%0d", i), 32'(bp_rs1),      32'(STAGED_BP_MEMORY));
            check($sformatf("hold.bp2_c%0d", i), 32'(bp_rs2),      32'(STAGED_BP_NONE));
            check($sformatf("hold.stl_c%0d", i), 32'(stall_dec),   32'd1);
            check($sformatf("hold.bub_c%0d", i), 32'(bubble_exec), 32'd0);
        end
        hold = 1'b0;
        #1;
        step();
        check("hold.rel_bp1", 32'(bp_rs1), 32'(STAGED_BP_NONE));
        check("hold.rel_bp2", 32'(bp_rs2), 32'(STAGED_BP_MEMORY));
        set_dec(1'b1, 5'd1, 5'd0, 5'd7, 1'b1, 1'b1);
        step();
        set_dec(1'b1, 5'd6, 5'd7, 5'd8, 1'b1, 1'b0);
        step();
        check("hrst.state_wait", 32'(dbg.state), 32'(LU_WAIT));
        hold = 1'b1;
        step();
        check("hrst.state_held", 32'(dbg.state),   32'(LU_WAIT));
        check("hrst.bub_held",   32'(bubble_exec), 32'd1);
        rst = 1'b1;
        #1;
        check_reset_outs("hrst.in_rst");
        hold = 1'b0;
        step();
        rst = 1'b0;
        #1;
        step();
        check("hrst.bp1_after", 32'(bp_rs1),      32'(STAGED_BP_NONE));
        check("hrst.bp2_after", 32'(bp_rs2),      32'(STAGED_BP_NONE));
        check("hrst.exec_v",    32'(bubble_exec), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Safety net so the run always terminates.
    initial begin
        #100000;
        $display("FAIL timeout: got running want finished");
        $fatal(1, "timeout");
    end

endmodule
